intt_core_sequencer: RTL and testbench

- Sequences one intt_core instance through every stage of a LOG_N-stage inverse NTT.
- Per stage it generates log_m, mode, i, the upper/lower read addresses, the delayed write addresses and write enables, and the ping-pong bank selects.
- Drains the butterfly pipeline between stages so no stage reads a word before the previous stage has written it.
- Sits between the top-level INTT scheduler (start/done handshake) and the core's control inputs; the core datapath is unchanged.

---
 rtl/intt_core_sequencer.sv | 157 +++++++++++++++
 tb/tb_intt_core_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/intt_core_sequencer.sv
// rtl/intt_core_sequencer.sv - stage/address/bank sequencer for one intt_core through a LOG_N-stage inverse NTT
// Optional build macro: INTT_CTRL_CYCLE_COUNT_EN adds the cycle_count output.
module intt_core_sequencer #(
  parameter int LOG_CORE_COUNT = 4,
  parameter int ADDR_WIDTH     = 9,
  parameter int LOG_N          = 12,
  parameter int MODE0_LAST     = 10,
  parameter int MODE1_LAST     = 11,
  parameter int BF_LATENCY     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  use_direct,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            log_m,
  output logic [1:0]            mode,
  output logic [9:0]            i,
  output logic [ADDR_WIDTH-1:0] upper_read_address,
  output logic [ADDR_WIDTH-1:0] lower_read_address,
  output logic [ADDR_WIDTH-1:0] upper_write_address,
  output logic [ADDR_WIDTH-1:0] lower_write_address,
  output logic                  upper_write_enable,
  output logic                  lower_write_enable,
  output logic                  read_select,
  output logic                  write_select,
  output logic                  input_select
`ifdef INTT_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam int LAT = BF_LATENCY + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (ADDR_WIDTH > 10 || LOG_N > 15 || LOG_CORE_COUNT < 0 || LAT > 255) begin : g_param_check
    $error("intt_core_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_SWITCH, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   rd_cnt;
  logic [7:0]              drain_cnt;
  logic                    ud_lat;
  logic                    issue;
  logic [LAT-1:0]          pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_addr [LAT];

  function automatic logic [1:0] mode_of(input logic [3:0] lm);
    if (int'(lm) <= MODE0_LAST)      return 2'd0;
    else if (int'(lm) <= MODE1_LAST) return 2'd1;
    else                             return 2'd2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (rd_cnt == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 8'(LAT - 1))
          state_nxt = (log_m == 4'(LOG_N)) ? S_DONE : S_SWITCH;
      end
      S_SWITCH: begin
        busy      = 1'b1;
        state_nxt = S_RUN;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The read counter saturates at the last address; only SWITCH/DONE rewind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt      <= '0;
      drain_cnt   <= '0;
      ud_lat      <= 1'b0;
      log_m       <= 4'd1;
      mode        <= 2'd0;
      read_select <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ud_lat      <= use_direct;
          log_m       <= 4'd1;
          mode        <= mode_of(4'd1);
          rd_cnt      <= '0;
          read_select <= 1'b0;
        end
        S_RUN: begin
          drain_cnt <= '0;
          if (rd_cnt != LAST_ADDR) rd_cnt <= rd_cnt + 1'b1;
        end
        S_DRAIN:  drain_cnt <= drain_cnt + 8'd1;
        S_SWITCH: begin
          read_select <= ~read_select;
          log_m       <= log_m + 4'd1;
          mode        <= mode_of(log_m + 4'd1);
          rd_cnt      <= '0;
        end
        S_DONE:   rd_cnt <= '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < LAT; k++) pipe_addr[k] <= '0;
    end else begin
      pipe_vld     <= {pipe_vld[LAT-2:0], issue};
      pipe_addr[0] <= rd_cnt;
      for (int k = 1; k < LAT; k++) pipe_addr[k] <= pipe_addr[k-1];
    end
  end

`ifdef INTT_CTRL_CYCLE_COUNT_EN
  // Counts every cycle of the run, including the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cycle_count <= '0;
    else if (state == S_IDLE && start) cycle_count <= '0;
    else if (state != S_IDLE)          cycle_count <= cycle_count + 32'd1;
  end
`endif

  assign i                   = 10'(rd_cnt);
  assign upper_read_address  = rd_cnt;
  assign lower_read_address  = rd_cnt;
  assign upper_write_address = pipe_addr[LAT-1];
  assign lower_write_address = pipe_addr[LAT-1];
  assign upper_write_enable  = pipe_vld[LAT-1];
  assign lower_write_enable  = pipe_vld[LAT-1];
  assign write_select        = ~read_select;
  assign input_select        = ud_lat & issue & (log_m == 4'd1);

endmodule

// File: tb/tb_intt_core_sequencer.sv
// tb/tb_intt_core_sequencer.sv - randomized check of intt_core_sequencer against a stage/cycle reference model
module tb_intt_core_sequencer;

  localparam int AW    = 2;
  localparam int LN    = 3;
  localparam int BF    = 3;
  localparam int M0    = 1;
  localparam int M1    = 2;
  localparam int WORDS = 1 << AW;
  localparam int L     = BF + 2;
  localparam int SL    = WORDS + L + 1;
  localparam int TOT   = LN * SL;

  logic          clk = 1'b0;
  logic          rst_n, start, use_direct;
  logic          busy, done;
  logic [3:0]    log_m;
  logic [1:0]    mode;
  logic [9:0]    i;
  logic [AW-1:0] ura, lra, uwa, lwa;
  logic          uwe, lwe, rsel, wsel, isel;
`ifdef INTT_CTRL_CYCLE_COUNT_EN
  logic [31:0]   cycle_count;
`endif

  intt_core_sequencer #(
    .LOG_CORE_COUNT(4), .ADDR_WIDTH(AW), .LOG_N(LN),
    .MODE0_LAST(M0), .MODE1_LAST(M1), .BF_LATENCY(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_direct(use_direct),
    .busy(busy), .done(done), .log_m(log_m), .mode(mode), .i(i),
    .upper_read_address(ura), .lower_read_address(lra),
    .upper_write_address(uwa), .lower_write_address(lwa),
    .upper_write_enable(uwe), .lower_write_enable(lwe),
    .read_select(rsel), .write_select(wsel), .input_select(isel)
`ifdef INTT_CTRL_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: k = cycles since start acceptance (0 = idle); expected outputs follow from stage/phase arithmetic.
  int k = 0;
  bit fresh = 1'b1;
  bit ud_m = 1'b0;
  int cc_m = 0;
  int hist_ra[L];
  bit hist_is[L];

  function automatic int mode_of(input int lm);
    if (lm <= M0) return 0;
    if (lm <= M1) return 1;
    return 2;
  endfunction

  task automatic step(input logic st, input logic ud_i, input logic rn);
    int s, p, e_lm, e_ra, e_rs;
    bit e_busy, e_done, e_issue;
    @(negedge clk);
    start = st; use_direct = ud_i; rst_n = rn;
    #1;
    if (!rn) begin
      k = 0; fresh = 1'b1; cc_m = 0;
      for (int n = 0; n < L; n++) begin hist_ra[n] = 0; hist_is[n] = 1'b0; end
    end
    if (k == 0) begin
      e_busy = 1'b0; e_done = 1'b0; e_issue = 1'b0; e_ra = 0;
      e_lm = fresh ? 1 : LN;
      e_rs = fresh ? 0 : (LN - 1) % 2;
    end else begin
      s = (k - 1) / SL + 1;
      p = (k - 1) % SL;
      e_busy  = (k < TOT);
      e_done  = (k == TOT);
      e_issue = (p < WORDS);
      e_ra    = e_issue ? p : WORDS - 1;
      e_lm    = s;
      e_rs    = (s - 1) % 2;
    end
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("log_m", log_m, e_lm);
    check("mode", mode, mode_of(e_lm));
    check("i", i, e_ra);
    check("upper_rd_addr", ura, e_ra);
    check("lower_rd_addr", lra, e_ra);
    check("upper_wr_addr", uwa, hist_ra[L-1]);
    check("lower_wr_addr", lwa, hist_ra[L-1]);
    check("upper_wr_en", uwe, hist_is[L-1]);
    check("lower_wr_en", lwe, hist_is[L-1]);
    check("read_select", rsel, e_rs);
    check("write_select", wsel, 1 - e_rs);
    check("input_select", isel, (ud_m && e_issue && e_lm == 1) ? 1 : 0);
`ifdef INTT_CTRL_CYCLE_COUNT_EN
    check("cycle_count", cycle_count, cc_m);
`endif
    @(posedge clk);
    if (rn) begin
      for (int n = L - 1; n > 0; n--) begin hist_ra[n] = hist_ra[n-1]; hist_is[n] = hist_is[n-1]; end
      hist_ra[0] = e_ra;
      hist_is[0] = e_issue;
      if (k == 0) begin
        if (st) begin k = 1; ud_m = ud_i; cc_m = 0; end
      end else begin
        cc_m++;
        if (k == TOT) begin k = 0; fresh = 1'b0; end
        else k++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; use_direct = 1'b0;
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    // Run with direct inputs; starts at relative cycles 5 and 30 are ignored, 31 is accepted.
    step(1, 1, 1);
    for (int c = 1; c <= 64; c++) step((c == 5 || c == 30 || c == 31), (c == 31) ? 1'b0 : 1'b1, 1'b1);
    // Abort at relative cycle 12, then a full run after release.
    step(1, 0, 1);
    for (int c = 1; c <= 11; c++) step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    for (int c = 1; c <= 33; c++) step(0, 1, 1);
    for (int c = 0; c < 3000; c++)
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 399) != 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
